// File: rtl/rr_resource_arbiter_if.sv
// Request/grant bundle between requester FSMs and the round-robin arbiter.
// The arbiter uses the slave modport; requesters (or a bench) use master.
interface rr_resource_arbiter_if #(
  parameter int N = 4
);
  localparam int ID_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_id;
  logic            busy;
  logic            preempt;

  modport master (output req, input gnt, gnt_id, busy, preempt);
  modport slave  (input req, output gnt, gnt_id, busy, preempt);
endinterface

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter for one multi-cycle shared resource: registered sticky
// one-hot grant with an optional hold limit that forces rotation.
module rr_resource_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_resource_arbiter_if.slave arb
);
  localparam int ID_W = (N > 1) ? $clog2(N) : 1;
  localparam int HC_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] CNT_MAX = (MAX_HOLD == 0) ? '0 : HC_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } pick_t;

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0] cnt_q, cnt_d;
  logic            pre_q, pre_d;
  logic [N-1:0]    others;
  pick_t           idle_pick, next_pick;

  function automatic logic [ID_W-1:0] inc_mod(input logic [ID_W-1:0] v);
    return (int'(v) == N - 1) ? '0 : v + ID_W'(1);
  endfunction

  // First set bit of r scanning upward from start, wrapping mod N.
  function automatic pick_t search(input logic [N-1:0] r, input logic [ID_W-1:0] start);
    pick_t p;
    int    j;
    p = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(start) + i;
      if (j >= N) j -= N;
      if (!p.found && r[j]) begin
        p.found = 1'b1;
        p.idx   = ID_W'(j);
      end
    end
    return p;
  endfunction

  // The holder is masked out so a forced rotation never lands back on it.
  assign others    = arb.req & ~gnt_q;
  assign idle_pick = search(arb.req, ptr_q);
  assign next_pick = search(others, inc_mod(id_q));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; that is what keeps this block from inferring latches.
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pre_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (idle_pick.found) begin
          state_d                = GRANT;
          gnt_d                  = '0;
          gnt_d[idle_pick.idx]   = 1'b1;
          id_d                   = idle_pick.idx;
          cnt_d                  = '0;
        end
      end

      GRANT: begin
        if (!arb.req[id_q]) begin
          ptr_d = inc_mod(id_q);
          if (next_pick.found) begin
            gnt_d                = '0;
            gnt_d[next_pick.idx] = 1'b1;
            id_d                 = next_pick.idx;
            cnt_d                = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (MAX_HOLD != 0 && cnt_q == CNT_MAX && next_pick.found) begin
          ptr_d                = inc_mod(id_q);
          gnt_d                = '0;
          gnt_d[next_pick.idx] = 1'b1;
          id_d                 = next_pick.idx;
          cnt_d                = '0;
          pre_d                = 1'b1;
        end else if (MAX_HOLD != 0 && cnt_q != CNT_MAX) begin
          // A lone holder parks at CNT_MAX so a late arrival rotates promptly.
          cnt_d = cnt_q + HC_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
    end
  end

  assign arb.gnt     = gnt_q;
  assign arb.gnt_id  = id_q;
  assign arb.busy    = |gnt_q;
  assign arb.preempt = pre_q;
endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed scenarios plus a randomized run checked against a queue-based
// model of the round-robin rules.
module tb_rr_resource_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  rr_resource_arbiter_if #(.N(N)) bus ();

  rr_resource_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  always #5 clk = ~clk;

  // Model state: holder index (-1 when idle), last granted id, priority
  // start, consecutive grant cycles of the current holder, preempt pulse.
  int m_holder = -1;
  int m_id     = 0;
  int m_ptr    = 0;
  int m_run    = 0;
  bit m_pre    = 1'b0;

  function automatic int pick_from(logic [N-1:0] r, int start, int exclude);
    int order[$];
    for (int i = 0; i < N; i++) order.push_back((start + i) % N);
    foreach (order[k]) if (order[k] != exclude && r[order[k]]) return order[k];
    return -1;
  endfunction

  task automatic model_step();
    logic [N-1:0] r;
    int w;
    r = bus.req;
    m_pre = 1'b0;
    if (rst) begin
      m_holder = -1; m_id = 0; m_ptr = 0; m_run = 0;
    end else if (m_holder < 0) begin
      w = pick_from(r, m_ptr, -1);
      if (w >= 0) begin m_holder = w; m_id = w; m_run = 1; end
    end else begin
      w = pick_from(r, (m_holder + 1) % N, m_holder);
      if (!r[m_holder]) begin
        m_ptr = (m_holder + 1) % N;
        m_holder = w;
        if (w >= 0) begin m_id = w; m_run = 1; end
      end else if (MAX_HOLD > 0 && m_run >= MAX_HOLD && w >= 0) begin
        m_ptr = (m_holder + 1) % N;
        m_holder = w; m_id = w; m_run = 1; m_pre = 1'b1;
      end else begin
        m_run++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [N-1:0] onehot(int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; bus.req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (bus.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      total++; if (bus.gnt_id !== 2'd0) begin bad++; $display("FAIL reset_gnt_id: got %0d want 0", bus.gnt_id); end
      total++; if (bus.preempt !== 1'b0) begin bad++; $display("FAIL reset_preempt: got %b want 0", bus.preempt); end
    end
    rst = 1'b0;
    tick();
    total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL reset_first_grant: got %b want 0001", bus.gnt); end
  endtask

  task automatic test_rotation();
    do_reset();
    bus.req = 4'b1111;
    tick();
    for (int k = 0; k < N; k++) begin
      for (int c = 0; c < 3; c++) begin
        total++; if (bus.gnt !== onehot(k)) begin bad++; $display("FAIL rot_hold%0d: got %b want %b", k, bus.gnt, onehot(k)); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rot_busy%0d: got %b want 1", k, bus.busy); end
        if (c == 2) bus.req[k] = 1'b0;
        tick();
      end
      bus.req[k] = 1'b1;
      total++; if (bus.gnt !== onehot((k + 1) % N)) begin bad++; $display("FAIL rot_handover%0d: got %b want %b", k, bus.gnt, onehot((k + 1) % N)); end
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rot_no_dead%0d: busy got %b want 1", k, bus.busy); end
      total++; if (bus.preempt !== 1'b0) begin bad++; $display("FAIL rot_preempt%0d: got %b want 0", k, bus.preempt); end
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    bus.req = 4'b0100; tick();
    total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL wrap_setup: got %b want 0100", bus.gnt); end
    bus.req = 4'b0000; tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL wrap_idle: busy got %b want 0", bus.busy); end
    total++; if (bus.gnt_id !== 2'd2) begin bad++; $display("FAIL wrap_id_hold: got %0d want 2", bus.gnt_id); end
    bus.req = 4'b0101; tick();
    total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL wrap_first: got %b want 0001", bus.gnt); end
    bus.req = 4'b0100; tick();
    total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL wrap_second: got %b want 0100", bus.gnt); end
    total++; if (bus.gnt_id !== 2'd2) begin bad++; $display("FAIL wrap_second_id: got %0d want 2", bus.gnt_id); end
  endtask

  task automatic test_hold_limit();
    do_reset();
    bus.req = 4'b0010; tick();
    tick();
    bus.req = 4'b1010;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL limit_hold%0d: got %b want 0010", c, bus.gnt); end
      total++; if (bus.preempt !== 1'b0) begin bad++; $display("FAIL limit_early_pre%0d: got %b want 0", c, bus.preempt); end
    end
    tick();
    total++; if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL limit_rotate: got %b want 1000", bus.gnt); end
    total++; if (bus.gnt_id !== 2'd3) begin bad++; $display("FAIL limit_rotate_id: got %0d want 3", bus.gnt_id); end
    total++; if (bus.preempt !== 1'b1) begin bad++; $display("FAIL limit_preempt: got %b want 1", bus.preempt); end
    tick();
    total++; if (bus.preempt !== 1'b0) begin bad++; $display("FAIL limit_pulse: got %b want 0", bus.preempt); end
    total++; if (bus.gnt !== 4'b1000) begin bad++; $display("FAIL limit_after: got %b want 1000", bus.gnt); end

    do_reset();
    bus.req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      tick();
      total++; if (bus.gnt !== 4'b0010 || bus.preempt !== 1'b0) begin
        bad++; $display("FAIL limit_alone%0d: got gnt=%b pre=%b want gnt=0010 pre=0", c, bus.gnt, bus.preempt);
      end
    end
  endtask

  task automatic test_simul_release_limit();
    do_reset();
    bus.req = 4'b0011;
    for (int c = 0; c < 4; c++) tick();
    total++; if (bus.gnt !== 4'b0001) begin bad++; $display("FAIL simul_setup: got %b want 0001", bus.gnt); end
    bus.req = 4'b0010; tick();
    total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL simul_gnt: got %b want 0010", bus.gnt); end
    total++; if (bus.preempt !== 1'b0) begin bad++; $display("FAIL simul_preempt: got %b want 0", bus.preempt); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.req = 4'b0100; tick(); tick();
    total++; if (bus.gnt !== 4'b0100) begin bad++; $display("FAIL midrst_setup: got %b want 0100", bus.gnt); end
    rst = 1'b1; tick();
    total++; if (bus.gnt !== 4'b0000 || bus.preempt !== 1'b0) begin
      bad++; $display("FAIL midrst_drop: got gnt=%b pre=%b want gnt=0000 pre=0", bus.gnt, bus.preempt);
    end
    rst = 1'b0; bus.req = 4'b0110; tick();
    total++; if (bus.gnt !== 4'b0010) begin bad++; $display("FAIL midrst_ptr0: got %b want 0010", bus.gnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) bus.req[i] = ~bus.req[i];
      rst = ($urandom_range(199) == 0);
      tick();
      total++;
      if (bus.gnt !== onehot(m_holder) || bus.gnt_id !== 2'(m_id) ||
          bus.busy !== (m_holder >= 0) || bus.preempt !== m_pre) begin
        bad++;
        $display("FAIL random_c%0d: got gnt=%b id=%0d busy=%b pre=%b want gnt=%b id=%0d busy=%b pre=%b",
                 c, bus.gnt, bus.gnt_id, bus.busy, bus.preempt,
                 onehot(m_holder), m_id, (m_holder >= 0), m_pre);
      end
      total++;
      if (!$onehot0(bus.gnt) || bus.busy !== (|bus.gnt) ||
          (bus.busy && bus.gnt[bus.gnt_id] !== 1'b1)) begin
        bad++;
        $display("FAIL invariant_c%0d: got gnt=%b id=%0d busy=%b want onehot0, busy==|gnt, gnt[id]=1",
                 c, bus.gnt, bus.gnt_id, bus.busy);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.req = '0;
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_hold_limit();
    test_simul_release_limit();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_resource_arbiter.md
Name: rr_resource_arbiter

Overview:
- Round-robin arbiter that shares one multi-cycle resource between N requesters. Example resources: a wide adder/ALU or memory port built from the gate-cell library.
- Grants are registered, one-hot and sticky while the holder keeps requesting.
- An optional hold limit forces rotation when other requesters are waiting.
- Sits between requester FSMs and the shared datapath; gnt_id drives the datapath input mux select.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_HOLD, 16, maximum consecutive grant cycles before forced rotation if others are pending; 0 disables the limit.
- ID_W, $clog2(N), width of gnt_id (derived, not overridden).

Ports:
- clk  input  1  single design clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  level request per requester; held high for as long as access is wanted.
- gnt  output  N  one-hot grant, registered; all-zero when idle.
- gnt_id  output  ID_W  binary index of the current holder; holds its last value when idle.
- busy  output  1  high while any gnt bit is set.
- preempt  output  1  one-cycle pulse on the cycle a grant was forcibly rotated by the hold limit.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values (effective on the first edge with rst=1): gnt=0, gnt_id=0, busy=0, preempt=0, priority pointer ptr=0, hold counter=0, state IDLE.
- rst overrides everything, including mid-grant; the grant drops on that edge with no preempt.
- State IDLE:
  - If req!=0 at an edge, pick the winner by searching from index ptr upward, wrapping mod N.
  - Next: gnt=onehot(winner), gnt_id=winner, busy=1, hold counter=0, state GRANT.
  - Latency: req rising before edge k gives gnt high after edge k (1 cycle).
- State GRANT, evaluated each edge with holder h:
  - Release: req[h]=0.
    - Grant passes directly to the next winner, searched from (h+1) mod N. No dead cycle.
    - If no other request is pending, go to IDLE with gnt=0.
    - ptr=(h+1) mod N.
  - Forced rotation: MAX_HOLD!=0, hold counter==MAX_HOLD-1, req[h]=1, and some other req bit set.
    - Grant moves to the next winner searched from (h+1) mod N, excluding h.
    - preempt=1 for exactly one cycle; ptr=(h+1) mod N.
  - Otherwise: the grant holds and the hold counter increments.
    - The counter saturates at MAX_HOLD-1 when the holder is alone; no rotation and no preempt.
- A preempted requester keeps req high and competes normally; it is now lowest priority.
- Release and hold-limit on the same edge: treat as a normal release, preempt=0.
- The hold counter resets to 0 on every new grant, including a re-grant to the same index after IDLE.
- Invariants, checked every cycle:
  - gnt is always one-hot or zero.
  - busy == |gnt.
  - gnt_id matches gnt whenever busy=1.
- Grant goes only to an index whose req was high at the deciding edge.
- Width rules:
  - Pointer and index arithmetic is mod N; N need not be a power of two.
  - Hold counter width is $clog2(MAX_HOLD) (min 1).
- No combinational path from req to any output.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with req=4'b1111, then rst=0.
  - During reset: gnt=0, busy=0, gnt_id=0.
  - First edge after release: gnt=4'b0001.
- Rotation fairness: N=4, MAX_HOLD=0, req=4'b1111 constant, each holder drops req for one cycle after 3 cycles of grant.
  - Grant order 0,1,2,3,0.
  - Handover has no dead cycle; busy stays 1.
- Wrap and skip: ptr=3 (after a grant to index 2), req=4'b0101.
  - Next grant is index 0.
  - After index 0 releases, index 2 is granted.
- Hold limit: MAX_HOLD=4, req[1] held high, req[3] raised on cycle 2 of grant 1.
  - gnt moves 4'b0010 -> 4'b1000 after exactly 4 grant cycles; preempt=1 for 1 cycle.
  - With req[3] absent, index 1 holds indefinitely and preempt stays 0.
- Simultaneous release and limit: MAX_HOLD=4, holder drops req on its 4th cycle while another req is pending.
  - Grant moves to the next requester with preempt=0.
- Mid-grant reset: rst=1 while gnt=4'b0100.
  - Next edge: gnt=0, ptr=0.
  - After reset with req=4'b0110: index 1 is granted first.
